bsg_manycore_link_sif_retimer: RTL and testbench



---
 rtl/bsg_manycore_link_sif_retimer_pkg.sv | 61 ++++++
 rtl/bsg_manycore_link_sif_retimer_two_fifo.sv | 83 ++++++++
 rtl/bsg_manycore_link_sif_retimer.sv | 153 +++++++++++++++
 tb/tb_bsg_manycore_link_sif_retimer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_sif_retimer_pkg.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_sif_retimer_pkg
//
// Purpose:
//   Shared definitions for the manycore link retimer: the request op and
//   return-type encodings, fixed field widths, and constant functions that
//   size the request packet, the return packet and a whole link_sif bundle
//   from the address / data / coordinate widths.
//
// Contents:
//   bsg_manycore_reg_id_width_gp        width of the reg_id field
//   bsg_manycore_packet_op_e            request packet opcode
//   bsg_manycore_return_packet_type_e   return packet type
//   bsg_manycore_packet_width()         bits in one request packet
//   bsg_manycore_return_packet_width()  bits in one return packet
//   bsg_manycore_link_sif_width()       bits in one link_sif bundle
// ---------------------------------------------------------------------------
package bsg_manycore_link_sif_retimer_pkg;

  localparam int bsg_manycore_reg_id_width_gp = 5;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2,
    e_cache_op     = 2'd3
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } bsg_manycore_return_packet_type_e;

  localparam int bsg_manycore_op_width_gp          = $bits(bsg_manycore_packet_op_e);
  localparam int bsg_manycore_return_type_width_gp = $bits(bsg_manycore_return_packet_type_e);

  // A request carries an address, opcode, reg_id, payload, and both the
  // source and destination coordinates.
  function automatic int bsg_manycore_packet_width(input int addr_w, input int data_w,
                                                   input int x_w, input int y_w);
    return addr_w + bsg_manycore_op_width_gp + bsg_manycore_reg_id_width_gp
           + data_w + 2 * (x_w + y_w);
  endfunction

  // A return only needs to find its way back, so it carries one coordinate pair.
  function automatic int bsg_manycore_return_packet_width(input int data_w,
                                                          input int x_w, input int y_w);
    return bsg_manycore_return_type_width_gp + data_w + bsg_manycore_reg_id_width_gp
           + x_w + y_w;
  endfunction

  // Each of the two sub-channels adds a valid bit and a ready bit around its packet.
  function automatic int bsg_manycore_link_sif_width(input int addr_w, input int data_w,
                                                     input int x_w, input int y_w);
    return 4 + bsg_manycore_packet_width(addr_w, data_w, x_w, y_w)
             + bsg_manycore_return_packet_width(data_w, x_w, y_w);
  endfunction

endpackage

// File: rtl/bsg_manycore_link_sif_retimer_two_fifo.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo
//
// Purpose:
//   Two-entry valid/ready FIFO used as a full-throughput retiming stage.
//   Both handshake outputs come straight from flops, so nothing on the far
//   side of the buffer reaches the near side combinationally.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset; empties the buffer
//   v_i          sender has a word on data_i
//   data_i       word to enqueue
//   ready_and_o  buffer is not full (registered)
//   v_o          buffer is not empty (registered)
//   data_o       head entry
//   ready_and_i  receiver takes the head entry when v_o is also high
// ---------------------------------------------------------------------------
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i
);

  logic [width_p-1:0] mem_q [2];
  logic [width_p-1:0] mem_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               enq, deq;

  // Next-state logic. Full and empty are tracked as separate flops so that
  // ready and valid are pure register outputs. Going full needs one entry
  // plus an enqueue without a dequeue; going empty needs one entry plus a
  // dequeue without an enqueue. A full buffer cannot enqueue, so any dequeue
  // from full leaves exactly one entry.
  always_comb begin
    enq      = v_i & ~full_q;
    deq      = ready_and_i & ~empty_q;
    mem_d    = mem_q;
    if (enq) begin
      mem_d[wr_ptr_q] = data_i;
    end
    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ enq;
    full_d   = full_q  ? ~deq : (~empty_q & enq & ~deq);
    empty_d  = empty_q ? ~enq : (~full_q & deq & ~enq);
  end

  // Control state. Reset drops every buffered word by forcing empty, which
  // also makes the buffer ready again on the first reset edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: an entry is only visible once empty_q says so.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign ready_and_o = ~full_q;
  assign v_o         = ~empty_q;
  assign data_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsg_manycore_link_sif_retimer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_sif_retimer
//
// Purpose:
//   Pipeline stage for one manycore mesh link between side A and side B.
//   All four channels (fwd A->B, fwd B->A, rev A->B, rev B->A) pass through
//   their own two-entry FIFO, adding one cycle of latency at full rate.
//   Channels share nothing, so a stall on one never holds up another.
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset
//   link_a_i  link_sif driven by side A (its link_out)
//   link_a_o  link_sif to side A (its link_in)
//   link_b_i  link_sif driven by side B
//   link_b_o  link_sif to side B
// ---------------------------------------------------------------------------
module bsg_manycore_link_sif_retimer
  import bsg_manycore_link_sif_retimer_pkg::*;
#(
  parameter  int addr_width_p   = 32,
  parameter  int data_width_p   = 32,
  parameter  int x_cord_width_p = 7,
  parameter  int y_cord_width_p = 7,
  localparam int link_sif_width_lp =
    bsg_manycore_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_sif_width_lp-1:0] link_a_i,
  output logic [link_sif_width_lp-1:0] link_a_o,
  input  logic [link_sif_width_lp-1:0] link_b_i,
  output logic [link_sif_width_lp-1:0] link_b_o
);

  typedef struct packed {
    logic [addr_width_p-1:0]                 addr;
    bsg_manycore_packet_op_e                 op;
    logic [bsg_manycore_reg_id_width_gp-1:0] reg_id;
    logic [data_width_p-1:0]                 payload;
    logic [y_cord_width_p-1:0]               src_y_cord;
    logic [x_cord_width_p-1:0]               src_x_cord;
    logic [y_cord_width_p-1:0]               y_cord;
    logic [x_cord_width_p-1:0]               x_cord;
  } packet_s;

  typedef struct packed {
    bsg_manycore_return_packet_type_e        pkt_type;
    logic [data_width_p-1:0]                 data;
    logic [bsg_manycore_reg_id_width_gp-1:0] reg_id;
    logic [y_cord_width_p-1:0]               y_cord;
    logic [x_cord_width_p-1:0]               x_cord;
  } return_packet_s;

  typedef struct packed {
    logic    v;
    packet_s data;
    logic    ready_and_rev;
  } fwd_link_sif_s;

  typedef struct packed {
    logic           v;
    return_packet_s data;
    logic           ready_and_rev;
  } rev_link_sif_s;

  typedef struct packed {
    rev_link_sif_s rev;
    fwd_link_sif_s fwd;
  } link_sif_s;

  localparam int packet_width_lp        = $bits(packet_s);
  localparam int return_packet_width_lp = $bits(return_packet_s);

  link_sif_s      link_a_in, link_b_in, link_a_out, link_b_out;

  logic           fwd_ab_ready, fwd_ab_v;
  packet_s        fwd_ab_data;
  logic           fwd_ba_ready, fwd_ba_v;
  packet_s        fwd_ba_data;
  logic           rev_ab_ready, rev_ab_v;
  return_packet_s rev_ab_data;
  logic           rev_ba_ready, rev_ba_v;
  return_packet_s rev_ba_data;

  assign link_a_in = link_a_i;
  assign link_b_in = link_b_i;
  assign link_a_o  = link_a_out;
  assign link_b_o  = link_b_out;

  bsg_two_fifo #(.width_p(packet_width_lp)) fwd_ab_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (link_a_in.fwd.v),
    .data_i     (link_a_in.fwd.data),
    .ready_and_o(fwd_ab_ready),
    .v_o        (fwd_ab_v),
    .data_o     (fwd_ab_data),
    .ready_and_i(link_b_in.fwd.ready_and_rev)
  );

  bsg_two_fifo #(.width_p(packet_width_lp)) fwd_ba_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (link_b_in.fwd.v),
    .data_i     (link_b_in.fwd.data),
    .ready_and_o(fwd_ba_ready),
    .v_o        (fwd_ba_v),
    .data_o     (fwd_ba_data),
    .ready_and_i(link_a_in.fwd.ready_and_rev)
  );

  bsg_two_fifo #(.width_p(return_packet_width_lp)) rev_ab_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (link_a_in.rev.v),
    .data_i     (link_a_in.rev.data),
    .ready_and_o(rev_ab_ready),
    .v_o        (rev_ab_v),
    .data_o     (rev_ab_data),
    .ready_and_i(link_b_in.rev.ready_and_rev)
  );

  bsg_two_fifo #(.width_p(return_packet_width_lp)) rev_ba_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (link_b_in.rev.v),
    .data_i     (link_b_in.rev.data),
    .ready_and_o(rev_ba_ready),
    .v_o        (rev_ba_v),
    .data_o     (rev_ba_data),
    .ready_and_i(link_a_in.rev.ready_and_rev)
  );

  // Reassemble each outgoing link_sif. A side's outgoing bundle carries the
  // traffic headed toward it plus the ready of the FIFO it feeds.
  always_comb begin
    link_a_out.fwd.v             = fwd_ba_v;
    link_a_out.fwd.data          = fwd_ba_data;
    link_a_out.fwd.ready_and_rev = fwd_ab_ready;
    link_a_out.rev.v             = rev_ba_v;
    link_a_out.rev.data          = rev_ba_data;
    link_a_out.rev.ready_and_rev = rev_ab_ready;

    link_b_out.fwd.v             = fwd_ab_v;
    link_b_out.fwd.data          = fwd_ab_data;
    link_b_out.fwd.ready_and_rev = fwd_ba_ready;
    link_b_out.rev.v             = rev_ab_v;
    link_b_out.rev.data          = rev_ab_data;
    link_b_out.rev.ready_and_rev = rev_ba_ready;
  end

endmodule

// File: tb/tb_bsg_manycore_link_sif_retimer.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_link_sif_retimer
//
// Drives all four link channels of the retimer from per-channel source
// queues. Every accepted packet goes into a per-channel expectation queue;
// a monitor pops and compares whenever a channel presents a packet that
// its receiver takes. Directed checks cover reset values, ready/valid
// timing under backpressure, and the mid-operation reset flush.
// Channel index: 0 fwd A->B, 1 fwd B->A, 2 rev A->B, 3 rev B->A.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_link_sif_retimer;

  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int XW     = 2;
  localparam int YW     = 2;
  localparam int PKT_W  = AW + 2 + 5 + DW + 2 * (XW + YW);
  localparam int RET_W  = 2 + DW + 5 + XW + YW;
  localparam int LINK_W = 4 + PKT_W + RET_W;

  typedef struct packed {
    logic             v;
    logic [PKT_W-1:0] data;
    logic             ready_and_rev;
  } fwd_t;

  typedef struct packed {
    logic             v;
    logic [RET_W-1:0] data;
    logic             ready_and_rev;
  } rev_t;

  typedef struct packed {
    rev_t rev;
    fwd_t fwd;
  } link_t;

  typedef struct {
    logic [PKT_W-1:0] data;
    int               cyc;
  } exp_t;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [LINK_W-1:0] link_a_i, link_a_o, link_b_i, link_b_o;
  link_t             a_in, b_in, a_out, b_out;

  logic              in_v    [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [PKT_W-1:0]  in_data [4] = '{'0, '0, '0, '0};
  logic              out_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic              v_en    [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic              lat_chk [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic              acc     [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic              v_force = 1'b1;
  int                rx_cnt  [4] = '{0, 0, 0, 0};

  logic              rdy_s [4];
  logic              ov    [4];
  logic [PKT_W-1:0]  od    [4];

  logic [PKT_W-1:0]  src_q [4][$];
  exp_t              exp_q [4][$];

  int                cyc   = 0;
  int                tests = 0;
  int                fails = 0;

  bsg_manycore_link_sif_retimer #(
    .addr_width_p  (AW),
    .data_width_p  (DW),
    .x_cord_width_p(XW),
    .y_cord_width_p(YW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .link_a_i(link_a_i),
    .link_a_o(link_a_o),
    .link_b_i(link_b_i),
    .link_b_o(link_b_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Map the per-channel sender/receiver variables onto the two link bundles.
  always_comb begin
    a_in = '0;
    b_in = '0;
    a_in.fwd.v             = in_v[0];
    a_in.fwd.data          = in_data[0];
    b_in.fwd.ready_and_rev = out_rdy[0];
    b_in.fwd.v             = in_v[1];
    b_in.fwd.data          = in_data[1];
    a_in.fwd.ready_and_rev = out_rdy[1];
    a_in.rev.v             = in_v[2];
    a_in.rev.data          = in_data[2][RET_W-1:0];
    b_in.rev.ready_and_rev = out_rdy[2];
    b_in.rev.v             = in_v[3];
    b_in.rev.data          = in_data[3][RET_W-1:0];
    a_in.rev.ready_and_rev = out_rdy[3];
  end

  assign link_a_i = a_in;
  assign link_b_i = b_in;
  assign a_out    = link_a_o;
  assign b_out    = link_b_o;

  // Per-channel view of the DUT: ready back to the sender, and the
  // valid/data presented to the receiver.
  always_comb begin
    rdy_s[0] = a_out.fwd.ready_and_rev;
    ov[0]    = b_out.fwd.v;
    od[0]    = b_out.fwd.data;
    rdy_s[1] = b_out.fwd.ready_and_rev;
    ov[1]    = a_out.fwd.v;
    od[1]    = a_out.fwd.data;
    rdy_s[2] = a_out.rev.ready_and_rev;
    ov[2]    = b_out.rev.v;
    od[2]    = PKT_W'(b_out.rev.data);
    rdy_s[3] = b_out.rev.ready_and_rev;
    ov[3]    = a_out.rev.v;
    od[3]    = PKT_W'(a_out.rev.data);
  end

  // Sender side: after each edge, retire an accepted packet and present the
  // next one from the source queue (or a dummy packet while v_force is on).
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < 4; c++) begin
      if (acc[c]) begin
        acc[c] = 1'b0;
        if (src_q[c].size() > 0) void'(src_q[c].pop_front());
      end
      if (v_force) begin
        in_v[c]    = 1'b1;
        in_data[c] = '0;
      end else if (v_en[c] && src_q[c].size() > 0) begin
        in_v[c]    = 1'b1;
        in_data[c] = src_q[c][0];
      end else begin
        in_v[c]    = 1'b0;
        in_data[c] = '0;
      end
    end
  end

  // Record every handshake the sender will complete at the coming edge as an
  // expected output, stamped with the cycle so latency can be checked.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (!reset && in_v[c] && rdy_s[c] === 1'b1) begin
        if (c >= 2) exp_q[c].push_back('{data: PKT_W'(in_data[c][RET_W-1:0]), cyc: cyc});
        else        exp_q[c].push_back('{data: in_data[c], cyc: cyc});
        acc[c] = 1'b1;
      end
    end
  end

  // Monitor: whenever a receiver takes a packet, it must be the oldest
  // outstanding one on that channel.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (ov[c] === 1'b1 && out_rdy[c]) begin
        rx_cnt[c] = rx_cnt[c] + 1;
        tests = tests + 1;
        if (exp_q[c].size() == 0) begin
          fails = fails + 1;
          $display("[TB] FAIL unexpected_ch%0d actual=%0h required=nothing", c, od[c]);
        end else begin
          e = exp_q[c].pop_front();
          if (od[c] !== e.data) begin
            fails = fails + 1;
            $display("[TB] FAIL data_ch%0d actual=%0h required=%0h", c, od[c], e.data);
          end
          if (lat_chk[c]) begin
            tests = tests + 1;
            if (cyc != e.cyc + 1) begin
              fails = fails + 1;
              $display("[TB] FAIL latency_ch%0d actual=%0d required=%0d", c, cyc - e.cyc, 1);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic [PKT_W-1:0] data);
    src_q[c].push_back(data);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    tests = tests + 1;
    if (actual !== required) begin
      fails = fails + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  initial begin
    int seq;
    seq = 0;

    // Reset held three cycles with every sender asserting valid.
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("reset%0d_v_ch%0d", k, c), 64'(ov[c]), 64'd0);
        checkOutput($sformatf("reset%0d_rdy_ch%0d", k, c), 64'(rdy_s[c]), 64'd1);
      end
    end
    reset   = 1'b0;
    v_force = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("post_reset_v_ch%0d", c), 64'(ov[c]), 64'd0);

    // Streaming 0x1..0x10 on fwd A->B with B always ready.
    lat_chk[0] = 1'b1;
    rx_cnt[0]  = 0;
    for (int i = 1; i <= 16; i++) applyStimulus(0, PKT_W'(i));
    v_en[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("stream_rdy_%0d", k), 64'(rdy_s[0]), 64'd1);
    end
    checkOutput("stream_count", 64'(rx_cnt[0]), 64'd16);
    lat_chk[0] = 1'b0;

    // Backpressure: B stalls while A offers 0xA, 0xB, 0xC.
    out_rdy[0] = 1'b0;
    rx_cnt[0]  = 0;
    applyStimulus(0, PKT_W'('hA));
    applyStimulus(0, PKT_W'('hB));
    applyStimulus(0, PKT_W'('hC));
    tick();
    checkOutput("bp1_rdy", 64'(rdy_s[0]), 64'd1);
    checkOutput("bp1_v", 64'(ov[0]), 64'd1);
    checkOutput("bp1_head", 64'(od[0]), 64'hA);
    tick();
    checkOutput("bp2_rdy", 64'(rdy_s[0]), 64'd0);
    checkOutput("bp2_head", 64'(od[0]), 64'hA);
    tick();
    checkOutput("bp3_rdy", 64'(rdy_s[0]), 64'd0);
    checkOutput("bp3_v", 64'(ov[0]), 64'd1);
    checkOutput("bp3_head", 64'(od[0]), 64'hA);
    checkOutput("bp3_sender_holds", 64'(in_v[0]), 64'd1);
    out_rdy[0] = 1'b1;
    tick();
    checkOutput("bp4_rdy", 64'(rdy_s[0]), 64'd1);
    checkOutput("bp4_head", 64'(od[0]), 64'hB);
    tick();
    checkOutput("bp5_head", 64'(od[0]), 64'hC);
    repeat (3) tick();
    checkOutput("bp_count", 64'(rx_cnt[0]), 64'd3);
    checkOutput("bp_drained", 64'(exp_q[0].size()), 64'd0);

    // Independence: rev B->A stalled while both fwd channels stream.
    out_rdy[3] = 1'b0;
    for (int c = 0; c < 4; c++) rx_cnt[c] = 0;
    for (int i = 0; i < 3; i++) applyStimulus(3, PKT_W'('h31 + i));
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, PKT_W'('h100 + i));
      applyStimulus(1, PKT_W'('h200 + i));
    end
    lat_chk[0] = 1'b1;
    lat_chk[1] = 1'b1;
    v_en[1]    = 1'b1;
    v_en[3]    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("indep_rdy0_%0d", k), 64'(rdy_s[0]), 64'd1);
      checkOutput($sformatf("indep_rdy1_%0d", k), 64'(rdy_s[1]), 64'd1);
    end
    checkOutput("indep_rev_full", 64'(rdy_s[3]), 64'd0);
    checkOutput("indep_count0", 64'(rx_cnt[0]), 64'd16);
    checkOutput("indep_count1", 64'(rx_cnt[1]), 64'd16);
    lat_chk[0] = 1'b0;
    lat_chk[1] = 1'b0;
    out_rdy[3] = 1'b1;
    repeat (6) tick();
    checkOutput("indep_count3", 64'(rx_cnt[3]), 64'd3);
    checkOutput("indep_drained3", 64'(exp_q[3].size()), 64'd0);

    // Mid-operation reset with both entries occupied on every channel.
    for (int c = 0; c < 4; c++) begin
      out_rdy[c] = 1'b0;
      v_en[c]    = 1'b1;
      applyStimulus(c, PKT_W'('h40 + 2 * c));
      applyStimulus(c, PKT_W'('h41 + 2 * c));
    end
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("full_rdy_ch%0d", c), 64'(rdy_s[c]), 64'd0);
      checkOutput($sformatf("full_v_ch%0d", c), 64'(ov[c]), 64'd1);
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("midrst_v_ch%0d", c), 64'(ov[c]), 64'd0);
      checkOutput($sformatf("midrst_rdy_ch%0d", c), 64'(rdy_s[c]), 64'd1);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      out_rdy[c] = 1'b1;
      rx_cnt[c]  = 0;
    end
    repeat (5) tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("midrst_none_ch%0d", c), 64'(rx_cnt[c]), 64'd0);
      checkOutput($sformatf("midrst_idle_ch%0d", c), 64'(ov[c]), 64'd0);
    end

    // Random valid/ready on all channels.
    for (int k = 0; k < 10000; k++) begin
      for (int c = 0; c < 4; c++) begin
        v_en[c]    = 1'($urandom_range(0, 1));
        out_rdy[c] = 1'($urandom_range(0, 1));
        if (src_q[c].size() < 2) begin
          applyStimulus(c, PKT_W'((c << 20) | seq));
          seq = seq + 1;
        end
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      v_en[c]    = 1'b0;
      out_rdy[c] = 1'b1;
    end
    repeat (5) tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rand_drained_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
      checkOutput($sformatf("rand_progress_ch%0d", c), 64'(rx_cnt[c] > 1000), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
